// File: rtl/am3341_fifo.sv
// -----------------------------------------------------------------------------
// am3341_fifo
//   Synchronous fall-through FIFO in the style of the Am3341 64x4 part.
//   An upstream stage shifts words in with si/ir. A downstream stage drains
//   them with so/ordy. q always presents the head word.
//
//   Optional feature: define AM3341_HALF_EN to add the half-full flag hf.
//
// Ports
//   clk   in   system clock; all state changes on posedge
//   mr_   in   master reset, asynchronous, active-low
//   d     in   [WIDTH] write data
//   si    in   shift-in request, active-high
//   ir    out  input ready (1 = not full)
//   so    in   shift-out request, active-high
//   ordy  out  output ready (1 = not empty). The data-book name "or" is a
//              SystemVerilog keyword, so the port is called ordy here.
//   q     out  [WIDTH] head word; 0 when empty; high-impedance when oe_=1
//   oe_   in   output enable for q, active-low
//   hf    out  half full, count >= DEPTH/2 (only with AM3341_HALF_EN)
//
// Handshake
//   A word is accepted at a posedge when si=1 and ir=1. A word is removed
//   at a posedge when so=1 and ordy=1. Both qualifiers are the values the
//   flags had before that edge. Requests made while the matching flag is 0
//   are dropped silently. A write and a read may both be accepted in the
//   same cycle.
// -----------------------------------------------------------------------------
module am3341_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clk,
   input  logic             mr_,
   input  logic [WIDTH-1:0] d,
   input  logic             si,
   output logic             ir,
   input  logic             so,
   output logic             ordy,
   output logic [WIDTH-1:0] q,
`ifdef AM3341_HALF_EN
   output logic             hf,
`endif
   input  logic             oe_
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   // Storage is intentionally not reset. Only the pointers and count are.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   logic             wr_acc;
   logic             rd_acc;

   // Full and empty are decoded from count. Pointer equality is ambiguous
   // once the pointers wrap.
   assign ir   = (count != FULL_CNT);
   assign ordy = (count != '0);

   assign wr_acc = si & ir;
   assign rd_acc = so & ordy;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= d;
      end
   end

   always_ff @(posedge clk or negedge mr_) begin
      if (!mr_) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // DEPTH is a power of two, so natural pointer overflow wraps
         // DEPTH-1 back to 0.
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Fall-through: a word written at edge N is the head right after edge N.
   // q reads 0 while empty so that stale memory never leaks out.
   assign q = oe_ ? {WIDTH{1'bz}} : (ordy ? mem[rd_ptr] : {WIDTH{1'b0}});

`ifdef AM3341_HALF_EN
   localparam logic [AW:0] HALF_CNT = (AW+1)'(DEPTH / 2);
   assign hf = (count >= HALF_CNT);
`endif

endmodule
